// File: rtl/lsu_port.sv
// Load/store initiator for one data-memory port: builds word address, byte mask and lane-shifted
// store data, splits word-crossing accesses in two, and aligns/extends returned load data.
module lsu_port #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_cen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {StIdle, StAcc2, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;  // word address of the second access
  logic [31:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  mask_hi_q, mask_hi_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d;
  logic        split_q, split_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [2:0]  req_size;
  logic [3:0]  req_base;
  logic        req_mis;
  logic [7:0]  req_mask;
  logic [63:0] req_lanes;
  logic [31:0] req_word;
  logic        accept;
  logic [63:0] ld_pair;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: begin req_size = 3'd1; req_base = 4'b0001; end
      3'b001, 3'b101: begin req_size = 3'd2; req_base = 4'b0011; end
      default:        begin req_size = 3'd4; req_base = 4'b1111; end
    endcase
  end

  // Bits [7:4] of the widened mask/data are exactly the part that spills into the next word.
  assign req_mis   = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
  assign req_mask  = {4'b0000, req_base} << req_addr[1:0];
  assign req_lanes = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  assign req_word  = {req_addr[31:2], 2'b00};
  assign req_ready = (state_q == StIdle) & ~reset;
  assign accept    = req_valid & req_ready;

  assign ld_pair = split_q ? {mem_data, lo_q} : {32'h0, mem_data};
  assign ld_word = 32'(ld_pair >> {off_q, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    lo_d        = lo_q;
    mask_hi_d   = mask_hi_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    we_d        = we_q;
    split_d     = split_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = 32'h0;
    mem_cen     = 1'b0;
    mem_addr    = 32'h0;
    mem_wmask   = 4'h0;
    mem_wdata   = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          off_d      = req_addr[1:0];
          split_d    = req_mis;
          addr_d     = req_word + 32'd4;
          mask_hi_d  = req_mask[7:4];
          wdata_hi_d = req_lanes[63:32];
          if (req_mis && !ALLOW_MISALIGN) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_cen  = 1'b1;
            mem_addr = req_word;
            if (req_we) begin
              mem_wmask = req_mask[3:0];
              mem_wdata = req_lanes[31:0];
            end
            if (req_mis)     state_d = StAcc2;
            else if (req_we) rsp_valid_d = 1'b1;
            else             state_d = StWait;
          end
        end
      end
      StAcc2: begin
        mem_cen  = 1'b1;
        mem_addr = addr_q;
        if (we_q) begin
          mem_wmask   = mask_hi_q;
          mem_wdata   = wdata_hi_q;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          lo_d    = mem_data;
          state_d = StWait;
        end
      end
      StWait: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ld_ext;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset suppresses any access still in flight, including the second half of a split store.
    if (reset) begin
      mem_cen   = 1'b0;
      mem_addr  = 32'h0;
      mem_wmask = 4'h0;
      mem_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      wdata_hi_q  <= 32'h0;
      lo_q        <= 32'h0;
      mask_hi_q   <= 4'h0;
      funct3_q    <= 3'h0;
      off_q       <= 2'h0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_hi_q  <= wdata_hi_d;
      lo_q        <= lo_d;
      mask_hi_q   <= mask_hi_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      we_q        <= we_d;
      split_q     <= split_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
